// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, with a start/done handshake and error shortcuts.
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   hi_ans,
  output logic [WIDTH:0]   lo_ans,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  logic [2*WIDTH:0]     acc;
  logic [WIDTH-1:0]     m_r;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div;
  logic                 neg_r;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     load_m;
  logic [WIDTH-1:0]     load_lo;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     mul_next;
  logic [2*WIDTH:0]     div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH:0]     div_next;
  logic [2*WIDTH-1:0]   fix_val;

  always_comb begin
    mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
    // Multiplicand in m_r and multiplier in acc low half; divisor in m_r and dividend in acc.
    case (op)
      2'b01:   begin load_m = mag_a;     load_lo = mag_b;     end
      2'b10:   begin load_m = operand_b; load_lo = operand_a; end
      default: begin load_m = operand_a; load_lo = operand_b; end
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
    mul_next = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : (acc >> 1);

    // Restoring step: shift partial remainder left, subtract divisor if it fits.
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, m_r};
    if (div_shift[2*WIDTH:WIDTH] >= {1'b0, m_r})
      div_next = {div_diff, div_shift[WIDTH-1:1], 1'b1};
    else
      div_next = div_shift;

    fix_val = neg_r ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      m_r         <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi_ans      <= '0;
      lo_ans      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (op == 2'b11) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              hi_ans      <= {1'b1, {WIDTH{1'b0}}};
              lo_ans      <= '0;
              div_by_zero <= 1'b0;
            end else if (op == 2'b10 && operand_b == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              hi_ans      <= {1'b1, operand_a};
              lo_ans      <= {1'b0, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              done        <= 1'b0;
              div_by_zero <= 1'b0;
              cnt         <= '0;
              is_div      <= op[1];
              neg_r       <= (op == 2'b01) && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              m_r         <= load_m;
              acc         <= {{(WIDTH+1){1'b0}}, load_lo};
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == CNT_W'(WIDTH-1))
            state <= FIX;
          else
            cnt <= cnt + 1'b1;
        end
        FIX: begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          hi_ans <= {1'b0, fix_val[2*WIDTH-1:WIDTH]};
          lo_ans <= {1'b0, fix_val[WIDTH-1:0]};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, error shortcuts,
// start-while-busy, mid-operation reset and back-to-back operation.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic [16:0] hi_ans;
  logic [16:0] lo_ans;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi_ans(hi_ans), .lo_ans(lo_ans),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic b, input logic d,
                           input logic [16:0] hi, input logic [16:0] lo, input logic z);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".hi"}, 32'(hi_ans), 32'(hi));
    check({tag, ".lo"}, 32'(lo_ans), 32'(lo));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(z));
  endtask

  // Drives start for exactly one edge (cycle 0); returns in cycle 1.
  task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_busy_run(input string tag, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".done"}, 32'(done), 32'd0);
      if (c < to) tick();
    end
  endtask

  initial begin
    tick(); tick();
    check_out("reset", 1'b0, 1'b0, 17'h0, 17'h0, 1'b0);
    reset = 1'b0;
    tick();

    // 1: unsigned 300*500 = 0x249F0
    launch(2'b00, 16'd300, 16'd500);
    operand_a = 16'd9; operand_b = 16'd9;
    expect_busy_run("umul", 1, 17);
    tick();
    check_out("umul.c18", 1'b0, 1'b1, 17'h00002, 17'h049F0, 1'b0);
    tick();
    check_out("umul.hold", 1'b0, 1'b0, 17'h00002, 17'h049F0, 1'b0);

    // 2: signed -3*7 = -21
    launch(2'b01, 16'hFFFD, 16'd7);
    repeat (17) tick();
    check_out("smul", 1'b0, 1'b1, 17'h0FFFF, 17'h0FFEB, 1'b0);
    tick();

    // 3: 1000/7 = 142 r 6
    launch(2'b10, 16'd1000, 16'd7);
    repeat (17) tick();
    check_out("udiv", 1'b0, 1'b1, 17'h00006, 17'h0008E, 1'b0);
    tick();

    // 4: divide by zero and illegal op complete in cycle 1
    launch(2'b10, 16'h04D2, 16'h0000);
    check_out("dbz", 1'b0, 1'b1, 17'h104D2, 17'h0FFFF, 1'b1);
    tick();
    check_out("dbz.hold", 1'b0, 1'b0, 17'h104D2, 17'h0FFFF, 1'b1);
    launch(2'b11, 16'h1234, 16'h5678);
    check_out("illegal", 1'b0, 1'b1, 17'h10000, 17'h00000, 1'b0);
    tick();

    // 5a: start re-pulsed in cycle 5 is ignored
    launch(2'b00, 16'd300, 16'd500);
    repeat (4) tick();
    op = 2'b01; operand_a = 16'd2; operand_b = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    expect_busy_run("ignore", 6, 17);
    tick();
    check_out("ignore.c18", 1'b0, 1'b1, 17'h00002, 17'h049F0, 1'b0);
    tick();

    // 5b: reset in cycle 8 aborts; then a fresh -32768*-32768
    launch(2'b00, 16'd1000, 16'd1000);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("abort", 1'b0, 1'b0, 17'h0, 17'h0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      tick();
      check("abort.nodone", 32'(done), 32'd0);
    end
    launch(2'b01, 16'h8000, 16'h8000);
    repeat (17) tick();
    check_out("smul.min", 1'b0, 1'b1, 17'h04000, 17'h00000, 1'b0);
    tick();

    // 6: back-to-back, start held through first DONE cycle
    launch(2'b01, 16'hFFFD, 16'd7);
    repeat (16) tick();
    op = 2'b10; operand_a = 16'd100; operand_b = 16'd10; start = 1'b1;
    tick();
    check_out("b2b.first", 1'b0, 1'b1, 17'h0FFFF, 17'h0FFEB, 1'b0);
    tick();
    start = 1'b0;
    check_out("b2b.c1", 1'b1, 1'b0, 17'h0FFFF, 17'h0FFEB, 1'b0);
    repeat (16) tick();
    check_out("b2b.c17", 1'b1, 1'b0, 17'h0FFFF, 17'h0FFEB, 1'b0);
    tick();
    check_out("b2b.second", 1'b0, 1'b1, 17'h00000, 17'h0000A, 1'b0);
    tick();
    check("b2b.idle", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit sitting directly upstream of the status register.
- Produces the 17-bit hi_ans/lo_ans pair that the status register and register file consume for opcode 10 (MUL/DIV class).
- Takes 16-bit operands from the operand-fetch stage with a start/done handshake.
- Uses radix-2 iterative shift-add multiply and restoring divide, one bit per clock.

Parameters:
- WIDTH, 16, operand width; hi_ans/lo_ans are WIDTH+1 bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- op  input  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 illegal.
- operand_a  input  16  multiplicand / dividend.
- operand_b  input  16  multiplier / divisor.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse; results valid in that cycle and held after it.
- hi_ans  output  17  mul: upper product half; div: remainder; bit16 = error flag.
- lo_ans  output  17  mul: lower product half; div: quotient; bit16 always 0.
- div_by_zero  output  1  set with done for a divide with divisor 0; held with results.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset value of every output is 0; state is IDLE.
- Reset overrides everything. A reset asserted mid-operation aborts the operation, produces no done pulse and clears the results.
- States:
  - IDLE -> CALC on start.
  - CALC (16 iterations) -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE, or -> CALC if start is asserted in DONE (back-to-back).
  - Error shortcut: IDLE/DONE -> DONE on start when op=11, or when op=10 and operand_b=0.
- Acceptance:
  - operand_a, operand_b and op are latched on the accepting edge.
  - Later input changes have no effect.
  - start in CALC or FIX is ignored, with no queueing.
- Latency:
  - Start sampled high in cycle 0 gives CALC in cycles 1-16, FIX in cycle 17, and done=1 in cycle 18.
  - Error shortcut gives done=1 in cycle 1.
- Unsigned mul: 32-bit product P. hi_ans={0,P[31:16]}, lo_ans={0,P[15:0]}.
- Signed mul:
  - Operands are converted to magnitudes at acceptance and multiplied unsigned.
  - FIX negates the 32-bit result if exactly one operand sign is set.
  - -32768*-32768 = 0x40000000, with no error.
- Unsigned div:
  - Restoring algorithm; quotient in lo_ans[15:0], remainder in hi_ans[15:0], bit16=0.
  - FIX is a pass-through cycle, so latency is identical to mul.
- Divide by zero: lo_ans=17'h0FFFF, hi_ans={1'b1,operand_a}, div_by_zero=1.
- Illegal op: hi_ans=17'h10000, lo_ans=0, div_by_zero=0.
- Result registers update only in the DONE-entry cycle.
  - They hold until the next accepted operation reaches DONE or reset occurs.
  - div_by_zero clears at the next acceptance.
- The iteration counter runs 0..15 and ends CALC at 15. It has no wrap-around; it is reloaded to 0 at acceptance.
- Internal accumulator is 33 bits, so no intermediate carry is lost. hi_ans bit16 is never a carry.

Test Plan:
1. Unsigned mul: op=00, a=300, b=500, start in cycle 0 -> busy cycles 1-17; done cycle 18 with hi_ans=17'h00002, lo_ans=17'h049F0, div_by_zero=0.
2. Signed mul: op=01, a=16'hFFFD (-3), b=7 -> cycle 18 hi_ans=17'h0FFFF, lo_ans=17'h0FFEB. Also a=b=16'h8000 -> hi_ans=17'h04000, lo_ans=0.
3. Divide: op=10, a=1000, b=7 -> cycle 18 lo_ans=17'h0008E, hi_ans=17'h00006.
4. Divide by zero and illegal op:
   - op=10, a=16'h04D2, b=0 -> done in cycle 1, hi_ans=17'h104D2, lo_ans=17'h0FFFF, div_by_zero=1.
   - op=11 -> done in cycle 1, hi_ans=17'h10000, lo_ans=0.
5. Busy and reset:
   - start a mul, re-pulse start with new operands in cycle 5 -> ignored, and the original result appears in cycle 18.
   - Repeat with reset in cycle 8 -> busy=0, all outputs 0 next cycle, no done.
   - A fresh start then completes normally after 18 cycles.
6. Back-to-back: start held high through the DONE cycle with new operands (op=10, 100/10) -> second done 18 cycles after the first, with lo_ans=17'h0000A, hi_ans=0. First results stay valid until the second done.
